// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - job sequencer driving a DSP48A1-style slice for unsigned dot products
// Feeds operand pairs with aligned OPMODE, drains the slice pipeline, then returns P on a valid/ready port.
module dsp_mac_sequencer #(
  parameter int LEN_W     = 8,
  parameter int OPM_DELAY = 1,
  parameter int RES_LAT   = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  input  logic [47:0]      dsp_P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (RES_LAT < 2) ? 1 : $clog2(RES_LAT + 1);
  localparam logic [7:0] OPM_CLEAR = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             first, first_n;
  logic [CNT_W-1:0] drain_cnt, drain_n;
  logic [17:0]      a_n, b_n;
  logic [7:0]       opm_op;
  logic             out_valid_n, done_n;
  logic [47:0]      out_data_n;
  logic             in_hs, out_hs;

  // Stage 0 is aligned with dsp_A/dsp_B; the remaining OPM_DELAY stages make OPMODE lag them.
  logic [7:0] opm_pipe [0:OPM_DELAY];

  assign in_hs      = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready;
  assign dsp_OPMODE = opm_pipe[OPM_DELAY];

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    first_n     = first;
    drain_n     = drain_cnt;
    a_n         = '0;
    b_n         = '0;
    opm_op      = 8'h00;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start && (len != '0)) begin
          state_n     = RUN;
          remaining_n = len;
          first_n     = 1'b1;
        end
      end
      RUN: begin
        // Bubbles before the first term also use the clearing OPMODE, so P starts from 0.
        opm_op = first ? OPM_CLEAR : OPM_ACC;
        if (in_hs) begin
          a_n         = in_a;
          b_n         = in_b;
          remaining_n = remaining - LEN_W'(1);
          first_n     = 1'b0;
          if (remaining == LEN_W'(1)) begin
            state_n = DRAIN;
            drain_n = CNT_W'(RES_LAT);
          end
        end
      end
      DRAIN: begin
        opm_op = OPM_ACC;
        if (drain_cnt == '0) begin
          out_data_n  = dsp_P;
          out_valid_n = 1'b1;
          state_n     = HOLD;
        end else begin
          drain_n = drain_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_hs) begin
          out_valid_n = 1'b0;
          done_n      = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      dsp_A     <= '0;
      dsp_B     <= '0;
      dsp_CE    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i <= OPM_DELAY; i++) opm_pipe[i] <= 8'h00;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      first     <= first_n;
      drain_cnt <= drain_n;
      in_ready  <= (state_n == RUN);
      dsp_A     <= a_n;
      dsp_B     <= b_n;
      // Slice P must stay frozen while the result waits in HOLD.
      dsp_CE    <= (state_n == RUN) || (state_n == DRAIN);
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
      opm_pipe[0] <= opm_op;
      for (int i = 1; i <= OPM_DELAY; i++) opm_pipe[i] <= opm_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - directed and random jobs against a slice model and a dot-product reference
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CE;
  logic [47:0] dsp_P;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] out_data;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] ja[$];
  logic [17:0] jb[$];

  dsp_mac_sequencer dut (
    .clk(clk), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE), .dsp_P(dsp_P),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Slice model: A1/B1, M, OPMODE and P registers on a common CE; never reset, starts with junk.
  logic [17:0] s_a1 = 18'h2A5A5;
  logic [17:0] s_b1 = 18'h15A5A;
  logic [35:0] s_m  = 36'h9_8765_4321;
  logic [7:0]  s_opm = 8'h09;
  logic [47:0] s_p  = 48'hDEAD_BEEF_1234;
  logic [47:0] s_x, s_z;

  assign s_x   = (s_opm[1:0] == 2'b01) ? {12'b0, s_m} : 48'd0;
  assign s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  assign dsp_P = s_p;

  always @(posedge clk) begin
    if (dsp_CE) begin
      s_a1  <= dsp_A;
      s_b1  <= dsp_B;
      s_m   <= 36'(s_a1) * 36'(s_b1);
      s_opm <= dsp_OPMODE;
      s_p   <= s_z + s_x;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input int gmin, input int gmax, input int hold, input bit poke);
    int n;
    int w;
    int lat;
    logic [47:0] exp;
    n   = ja.size();
    exp = 48'd0;
    for (int i = 0; i < n; i++) exp = exp + 48'(ja[i]) * 48'(jb[i]);
    out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " in_ready in RUN"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_a = 18'($urandom);
        in_b = 18'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_a = ja[i];
      in_b = jb[i];
      w = 0;
      while (!in_ready && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) check({tag, " accept timeout"}, 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " result latency"}, 64'(lat), 64'd4);
    check({tag, " result"}, 64'(out_data), 64'(exp));
    check({tag, " in_ready low at result"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        start = 1'b1;
        len   = 8'd3;
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold data"}, 64'(out_data), 64'(exp));
      check({tag, " hold no done/ready/ce"}, 64'({done, in_ready, dsp_CE}), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd1);
    check({tag, " valid dropped"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    check({tag, " idle after job"}, 64'({busy, in_ready}), 64'd0);
  endtask

  task automatic set_job(input logic [17:0] a0, input logic [17:0] b0);
    ja.push_back(a0);
    jb.push_back(b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset outputs", 64'({in_ready, dsp_A, dsp_B, dsp_OPMODE, dsp_CE, out_valid, busy, done}), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    RST = 1'b0;
    @(negedge clk);
    check("idle after reset", 64'({busy, in_ready, dsp_CE}), 64'd0);

    // T1 back-to-back, out_ready already high
    ja.delete(); jb.delete();
    for (int i = 1; i <= 4; i++) set_job(18'(i), 18'(i + 4));
    run_job("T1", 0, 0, 0, 1'b0);
    check("T1 value", 64'(out_data), 64'd70);

    // T2 same data with bubbles before and between terms
    run_job("T2", 1, 3, 0, 1'b0);
    check("T2 value", 64'(out_data), 64'd70);

    // T3 full-scale operands
    ja.delete(); jb.delete();
    set_job(18'h3FFFF, 18'h3FFFF);
    set_job(18'h3FFFF, 18'h3FFFF);
    run_job("T3", 0, 0, 0, 1'b0);
    check("T3 value", 64'(out_data), 64'h001F_FFF0_0002);

    // T4 held result, ignored start during HOLD
    ja.delete(); jb.delete();
    set_job(18'd7, 18'd9);
    run_job("T4", 0, 0, 5, 1'b1);
    check("T4 value", 64'(out_data), 64'd63);
    @(negedge clk);
    check("T4 start in HOLD ignored", 64'(busy), 64'd0);

    // T5 zero-length start ignored
    @(negedge clk);
    start = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("T5 len0 busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("T5 len0 stays idle", 64'({busy, in_ready, dsp_CE}), 64'd0);
    ja.delete(); jb.delete();
    set_job(18'd3, 18'd3);
    run_job("T5", 0, 0, 0, 1'b0);
    check("T5 value", 64'(out_data), 64'd9);

    // T6 asynchronous reset after 2 of 4 terms
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 18'($urandom);
      in_b = 18'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("T6 running before reset", 64'(busy), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("T6 async reset outputs", 64'({in_ready, dsp_A, dsp_B, dsp_OPMODE, dsp_CE, out_valid, busy, done}), 64'd0);
    check("T6 async reset out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    RST = 1'b0;
    ja.delete(); jb.delete();
    set_job(18'd3, 18'd3);
    run_job("T6", 0, 0, 0, 1'b0);
    check("T6 value", 64'(out_data), 64'd9);

    // Random jobs
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(12, 1));
      ja.delete(); jb.delete();
      for (int i = 0; i < n; i++) set_job(18'($urandom), 18'($urandom));
      run_job("RND", 0, 2, int'($urandom_range(3, 0)), 1'b0);
    end

    // Maximum term count with random operands
    ja.delete(); jb.delete();
    for (int i = 0; i < 255; i++) set_job(18'($urandom), 18'($urandom));
    run_job("MAXLEN", 0, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
